// File: rtl/sd_do_rx_pkg.sv
// Shared register map and bit positions for the SD DO receiver.
package sd_do_rx_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_OVERRUN    = 1;
  localparam int ST_BUSY       = 2;
  localparam int ST_BITCNT_LSB = 3;

  localparam int CTL_ENABLE = 0;
  localparam int CTL_IRQ_EN = 1;

  localparam int RAW_DO  = 0;
  localparam int RAW_CLK = 1;
endpackage

// File: rtl/sd_do_rx_sync.sv
// Multi-flop synchronizer with a run-time reset value.
module sd_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) ff <= {SYNC_STAGES{rst_val}};
    else       ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/sd_do_rx.sv
// SPI-mode SD card DO receiver with an Avalon-MM register slave.
// Optional interrupt output enabled by defining SD_DO_RX_IRQ_EN.
module sd_do_rx
  import sd_do_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sd_clk_in,
  input  logic        sd_do,
  input  logic        sd_cs_n
`ifdef SD_DO_RX_IRQ_EN
  ,
  output logic        irq
`endif
);
  // index 0 = sd_clk, 1 = sd_do, 2 = sd_cs_n; idle levels are the reset values
  localparam logic [2:0] SYNC_RST = 3'b110;

  logic [2:0] sync_in, sync_q;
  assign sync_in = {sd_cs_n, sd_do, sd_clk_in};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    sd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .rst_val(SYNC_RST[g]),
      .d      (sync_in[g]),
      .q      (sync_q[g])
    );
  end

  logic clk_s, do_s, cs_n_s, clk_q, rise;
  assign clk_s  = sync_q[0];
  assign do_s   = sync_q[1];
  assign cs_n_s = sync_q[2];
  assign rise   = clk_s & ~clk_q;

  logic [7:0] shift_q, done_byte, rx_data, rx_data_nx;
  logic [2:0] bit_cnt;
  logic       done_pend;
  logic       rx_valid, overrun, enable, irq_en;
  logic       rx_valid_nx, overrun_nx, enable_nx, irq_en_nx;
  logic       rd_data, wr;

  assign rd_data = chipselect & ~read_n & (address == ADDR_DATA);
  assign wr      = chipselect & ~write_n;

  always_comb begin
    rx_valid_nx = rx_valid;
    overrun_nx  = overrun;
    rx_data_nx  = rx_data;
    enable_nx   = enable;
    irq_en_nx   = 1'b0;
`ifdef SD_DO_RX_IRQ_EN
    irq_en_nx   = irq_en;
    if (wr && address == ADDR_CONTROL) irq_en_nx = writedata[CTL_IRQ_EN];
`endif
    if (wr && address == ADDR_CONTROL) enable_nx = writedata[CTL_ENABLE];
    if (wr && address == ADDR_STATUS && writedata[ST_OVERRUN]) overrun_nx = 1'b0;
    // A DATA read landing on the completion cycle frees the slot for the new byte
    if (done_pend) begin
      if (rx_valid && !rd_data) overrun_nx = 1'b1;
      else begin
        rx_data_nx  = done_byte;
        rx_valid_nx = 1'b1;
      end
    end else if (rd_data) begin
      rx_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      done_pend <= 1'b0;
      done_byte <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      enable    <= 1'b0;
    end else begin
      clk_q     <= clk_s;
      done_pend <= 1'b0;
      rx_data   <= rx_data_nx;
      rx_valid  <= rx_valid_nx;
      overrun   <= overrun_nx;
      enable    <= enable_nx;
      if (cs_n_s || !enable) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (rise) begin
        shift_q <= {shift_q[6:0], do_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          done_pend <= 1'b1;
          done_byte <= {shift_q[6:0], do_s};
        end
      end
    end
  end

`ifdef SD_DO_RX_IRQ_EN
  // Built from next-state values so a DATA read drops irq on the following clock
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      irq_en <= irq_en_nx;
      irq    <= irq_en_nx & (rx_valid_nx | overrun_nx);
    end
  end
`else
  assign irq_en = 1'b0;
  logic unused_irq_en_nx;
  assign unused_irq_en_nx = irq_en_nx;
`endif

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[7:0] = rx_data;
      ADDR_STATUS: begin
        readdata[ST_RX_VALID]            = rx_valid;
        readdata[ST_OVERRUN]             = overrun;
        readdata[ST_BUSY]                = |bit_cnt;
        readdata[ST_BITCNT_LSB +: 3]     = bit_cnt;
      end
      ADDR_CONTROL: begin
        readdata[CTL_ENABLE] = enable;
        readdata[CTL_IRQ_EN] = irq_en;
      end
      default: begin
        readdata[RAW_DO]  = do_s;
        readdata[RAW_CLK] = clk_s;
      end
    endcase
  end
endmodule

// File: tb/tb_sd_do_rx.sv
// Self-checking bench for sd_do_rx: directed scenarios plus a randomized byte stream
// checked against a byte-level model of the receive register.
module tb_sd_do_rx;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata, readdata;
  logic        sd_clk_in, sd_do, sd_cs_n;
`ifdef SD_DO_RX_IRQ_EN
  logic        irq;
`endif

  sd_do_rx #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .sd_clk_in(sd_clk_in), .sd_do(sd_do), .sd_cs_n(sd_cs_n)
`ifdef SD_DO_RX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // byte-level model of the receive register
  logic [7:0] m_data;
  bit         m_valid, m_ovr;

  function automatic logic [31:0] exp_status();
    return {30'b0, m_ovr, m_valid};
  endfunction

  // returns what a same-cycle DATA read would see
  function automatic logic [7:0] model_complete(input logic [7:0] b, input bit rd_same);
    logic [7:0] old;
    old = m_data;
    if (rd_same) begin
      m_data = b; m_valid = 1'b1;
    end else if (m_valid) m_ovr = 1'b1;
    else begin
      m_data = b; m_valid = 1'b1;
    end
    return old;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk); d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
    if (a == 2'd0) m_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    if (a == 2'd1 && d[1]) m_ovr = 1'b0;
  endtask

  // clk/8 serial clock, MSB first; on bit 8 probes the completion cycle and the one after
  task automatic send_bits(input logic [7:0] v, input int n, input bit rd_done,
                           output logic [31:0] rdv, output logic [31:0] st_pre,
                           output logic [31:0] st_post);
    rdv = '0; st_pre = '0; st_post = '0;
    for (int i = 0; i < n; i++) begin
      sd_do = v[7-i]; sd_clk_in = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      sd_clk_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
        if (i == 7 && k == S) begin
          chipselect = 1'b1; read_n = 1'b0; address = rd_done ? 2'd0 : 2'd1;
          @(negedge clk);
          if (rd_done) rdv = readdata; else st_pre = readdata;
        end else if (i == 7 && k == S + 1) begin
          chipselect = 1'b1; read_n = 1'b0; address = 2'd1;
          @(negedge clk); st_post = readdata;
        end
      end
      if (i == 7) begin
        @(posedge clk); #1;
        chipselect = 1'b0; read_n = 1'b1;
      end
    end
    sd_clk_in = 1'b0;
    idle(2);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    sd_clk_in = 1'b0; sd_do = 1'b1; sd_cs_n = 1'b1;
    do_reset();
    bus_read(2'd0, d); chk("reset_data", d, 32'h0);
    bus_read(2'd1, d); chk("reset_status", d, 32'h0);
    bus_read(2'd2, d); chk("reset_control", d, 32'h0);
    bus_read(2'd3, d); chk("reset_raw", d, 32'h1);
`ifdef SD_DO_RX_IRQ_EN
    chk("reset_irq", {31'b0, irq}, 32'h0);
`endif
    sd_do = 1'b0; sd_clk_in = 1'b1; idle(S + 1);
    bus_read(2'd3, d); chk("raw_clk_hi_do_lo", d, 32'h2);
    sd_do = 1'b1; sd_clk_in = 1'b0; idle(S + 1);
  endtask

  task automatic test_single();
    logic [31:0] rdv, pre, post, d;
    bus_write(2'd2, 32'h1);
    sd_cs_n = 1'b0; idle(S + 1);
    send_bits(8'hA5, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'hA5, 1'b0));
    chk("single_status_before", pre, 32'h0);
    chk("single_status_after", post, exp_status());
    bus_read(2'd0, d); chk("single_data", d, 32'hA5);
    bus_read(2'd1, d); chk("single_status_cleared", d, exp_status());
  endtask

  task automatic test_overrun();
    logic [31:0] rdv, pre, post, d;
    send_bits(8'h3C, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'h3C, 1'b0));
    send_bits(8'hC3, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'hC3, 1'b0));
    chk("ovr_status", post, 32'h3);
    bus_read(2'd0, d); chk("ovr_data_kept", d, 32'h3C);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, d); chk("ovr_cleared", d, exp_status());
  endtask

  task automatic test_abort();
    logic [31:0] rdv, pre, post, d;
    send_bits(8'hE8, 5, 1'b0, rdv, pre, post);
    bus_read(2'd1, d); chk("abort_partial_status", d, (32'd5 << 3) | 32'h4);
    sd_cs_n = 1'b1; idle(S + 2);
    bus_read(2'd1, d); chk("abort_cnt_cleared", d, exp_status());
    sd_cs_n = 1'b0; idle(S + 1);
    send_bits(8'h81, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'h81, 1'b0));
    bus_read(2'd0, d); chk("abort_next_byte", d, 32'h81);
  endtask

  task automatic test_read_collide();
    logic [31:0] rdv, pre, post, d;
    logic [7:0]  old;
    send_bits(8'h11, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'h11, 1'b0));
    send_bits(8'h5A, 8, 1'b1, rdv, pre, post);
    old = model_complete(8'h5A, 1'b1);
    chk("collide_read_old", rdv, {24'b0, old});
    chk("collide_status", post, 32'h1);
    bus_read(2'd0, d); chk("collide_data_new", d, 32'h5A);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rdv, pre, post, d;
    send_bits(8'hFF, 4, 1'b0, rdv, pre, post);
    do_reset();
    idle(12);
    bus_read(2'd1, d); chk("midreset_status", d, 32'h0);
    bus_read(2'd2, d); chk("midreset_control", d, 32'h0);
    bus_write(2'd2, 32'h1);
    send_bits(8'h0F, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'h0F, 1'b0));
    chk("midreset_next_status", post, 32'h1);
    bus_read(2'd0, d); chk("midreset_next_data", d, 32'h0F);
  endtask

  task automatic test_disabled();
    logic [31:0] rdv, pre, post, d;
    bus_write(2'd2, 32'h0);
    send_bits(8'h77, 8, 1'b0, rdv, pre, post);
    bus_read(2'd1, d); chk("disabled_no_byte", d, exp_status());
    bus_write(2'd2, 32'h1);
  endtask

  task automatic test_random();
    logic [31:0] rdv, pre, post, d;
    logic [7:0]  b, old;
    int          mode;
    for (int it = 0; it < 24; it++) begin
      b = 8'($urandom);
      mode = int'($urandom_range(0, 3));
      send_bits(b, 8, mode == 2, rdv, pre, post);
      old = model_complete(b, mode == 2);
      if (mode == 2) chk("rand_collide_read", rdv, {24'b0, old});
      chk("rand_status", post, exp_status());
      if (mode == 0) begin
        bus_read(2'd0, d); chk("rand_data", d, {24'b0, m_data});
      end else if (mode == 3 && m_ovr) begin
        bus_write(2'd1, 32'h2);
        bus_read(2'd1, d); chk("rand_ovr_clear", d, exp_status());
      end
    end
    bus_read(2'd0, d); chk("rand_final_data", d, {24'b0, m_data});
  endtask

  task automatic test_irq();
    logic [31:0] rdv, pre, post, d;
`ifdef SD_DO_RX_IRQ_EN
    bus_write(2'd1, 32'h2);
    bus_write(2'd2, 32'h3);
    chk("irq_idle", {31'b0, irq}, 32'h0);
    send_bits(8'h42, 8, 1'b0, rdv, pre, post);
    void'(model_complete(8'h42, 1'b0));
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_read(2'd0, d); chk("irq_data", d, 32'h42);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
`else
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d); chk("ctrl_no_irq_en", d, 32'h1);
    rdv = '0; pre = '0; post = '0;
`endif
  endtask

  initial begin
    reset = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = '0; sd_clk_in = 1'b0; sd_do = 1'b1; sd_cs_n = 1'b1;
    m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_abort();
    test_read_collide();
    test_disabled();
    test_random();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sd_do_rx.md
SD_DO_RX -- requirements
Module: sd_do_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sd_clk_in/sd_do/sd_cs_n (legal 2..3).
REQ-002 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port address, input, 2, Avalon-MM slave register select.
REQ-005 SHALL have port chipselect, input, 1, slave select.
REQ-006 SHALL have port read_n, input, 1, active-low read strobe.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, combinational read data, zero wait states.
REQ-010 SHALL have port sd_clk_in, input, 1, SD SPI clock as driven onto the card, looped back.
REQ-011 SHALL have port sd_do, input, 1, card DO (MISO) line.
REQ-012 SHALL have port sd_cs_n, input, 1, card chip select, looped back.
REQ-013 SHALL have port irq, output, 1, receive interrupt; present only per REQ-030.

Function
REQ-014 SHALL pass sd_clk_in, sd_do, sd_cs_n through SYNC_STAGES flops each, equal delay.
REQ-015 SHALL detect a rising edge as synced sd_clk 0 in the previous cycle and 1 in the current cycle.
REQ-016 SHALL, on a rising edge with ENABLE=1 and synced sd_cs_n=0, shift synced sd_do into an 8-bit shift register MSB-first and increment a 3-bit bit counter.
REQ-017 SHALL, on the edge that takes the bit counter 7->0, load the completed byte into rx_data and set RX_VALID on the following clock.
REQ-018 SHALL, if a byte completes while RX_VALID=1, discard the new byte, keep rx_data, and set OVERRUN.
REQ-019 SHALL clear shift register and bit counter (not rx_data) whenever synced sd_cs_n=1 or ENABLE=0; a partial byte is dropped.
REQ-020 SHALL decode registers: addr0 DATA (read [7:0]=rx_data); addr1 STATUS ([0] RX_VALID, [1] OVERRUN, [2] BUSY = bit counter nonzero, [5:3] bit counter); addr2 CONTROL ([0] ENABLE, [1] IRQ_EN); addr3 RAW ([0] synced sd_do, [1] synced sd_clk); unused bits read 0.
REQ-021 SHALL clear RX_VALID on any cycle with chipselect=1, read_n=0, address=0.
REQ-022 SHALL, when a DATA read and a byte completion fall in the same cycle, return the old byte and leave RX_VALID=1 holding the new byte, with no OVERRUN.
REQ-023 SHALL clear OVERRUN on a STATUS write with writedata[1]=1; writes to DATA and RAW are ignored.
REQ-024 SHALL write CONTROL[1:0] from writedata[1:0] on chipselect=1, write_n=0, address=2.
REQ-025 SHALL sample at most one bit per rising sd_clk edge; sd_clk_in is assumed at most clk/4.

Reset
REQ-026 SHALL, on reset, clear all synchronizer flops to sd_clk=0, sd_do=1, sd_cs_n=1.
REQ-027 SHALL, on reset, clear shift register, bit counter, rx_data, RX_VALID, OVERRUN, ENABLE, IRQ_EN; readdata is then 0 except RAW; irq=0.
REQ-028 SHALL, on reset asserted mid-byte, abandon the byte with no RX_VALID set.

Configuration
REQ-029 SHALL use macro SD_DO_RX_IRQ_EN.
REQ-030 SHALL, with SD_DO_RX_IRQ_EN defined, implement irq = IRQ_EN & (RX_VALID | OVERRUN), registered; without it, the irq port is absent, CONTROL[1] reads 0, and writes to it are ignored.

Structure
REQ-031 SHALL place register address constants (DATA, STATUS, CONTROL, RAW) and STATUS/CONTROL bit indices in shared package sd_do_rx_pkg.
REQ-032 SHALL instantiate sub-module sd_sync for each synchronized input (parameter SYNC_STAGES, reset value port).

Verification
REQ-033 SHALL test: ENABLE=1, cs_n=0, shift 0xA5 MSB-first at clk/8 -> STATUS[0]=1 after 8th edge plus SYNC_STAGES+2 clocks; DATA reads 0xA5; STATUS[0]=0 afterwards.
REQ-034 SHALL test: two bytes 0x3C then 0xC3, no read between -> DATA=0x3C, STATUS[1]=1; write STATUS=0x2 -> STATUS[1]=0.
REQ-035 SHALL test: 5 bits shifted, cs_n raised, then 0x81 shifted -> DATA=0x81, no stale bits, STATUS[5:3]=0 while cs_n high.
REQ-036 SHALL test: DATA read issued in the byte-completion cycle of 0x5A after prior 0x11 -> read returns 0x11, STATUS[0]=1, DATA=0x5A, STATUS[1]=0.
REQ-037 SHALL test: reset pulsed after 4 bits of 0xFF -> STATUS=0, no RX_VALID; next full 0x0F received correctly.
REQ-038 SHALL test with SD_DO_RX_IRQ_EN: IRQ_EN=1, byte 0x42 received -> irq=1; DATA read -> irq=0 next clock.
